// File: rtl/cla512_rr_arbiter_if.sv
// Requester and response bundle shared by the round-robin arbiter and its clients.
interface cla512_rr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 512,
    parameter int ID_W   = $clog2(NREQ)
) ();
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_sum;
    logic                   rsp_cout;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/cla512_rr_arbiter.sv
// Round-robin issue into one shared registered 512-bit CLA adder; 2-cycle accept-to-response latency.
// Requests stall only by losing arbitration; responses have no backpressure (one op per cycle).

module cla512 #(
    parameter int W = 512
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int LV = $clog2(W);

    // Kogge-Stone prefix tree: g[LV][i] is the carry out of bit i (carry-in is 0).
    logic [W-1:0] g [0:LV];
    logic [W-1:0] p [0:LV-1];

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        assign g[l+1] = g[l] | (p[l] & (g[l] << (1 << l)));
        if (l < LV - 1) begin : g_prop
            assign p[l+1] = p[l] & (p[l] << (1 << l));
        end
    end

    assign sum  = p[0] ^ {g[LV][W-2:0], 1'b0};
    assign cout = g[LV][W-1];
endmodule

module cla512_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 512,
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic clk,
    input  logic rst_n,
    cla512_rr_arbiter_if.slave bus
);
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win_idx;
    logic              win_found;
    logic [NREQ-1:0]   grant;
    logic              accept;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [ID_W-1:0]   id1;
    logic              v1;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    always_comb begin
        logic [ID_W-1:0] cand;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        // Offset NREQ truncates back to ptr itself, so the last requester examined is the previous winner.
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        grant = '0;
        if (win_found && rst_n) begin
            grant = NREQ'(1) << win_idx;
        end
    end

    assign accept        = |grant;
    assign bus.req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= ID_W'(NREQ - 1);
            a_reg <= '0;
            b_reg <= '0;
            id1   <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                ptr   <= win_idx;
                a_reg <= bus.req_a[win_idx*DATA_W +: DATA_W];
                b_reg <= bus.req_b[win_idx*DATA_W +: DATA_W];
                id1   <= win_idx;
            end
        end
    end

    cla512 #(.W(DATA_W)) u_add (
        .a    (a_reg),
        .b    (b_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
        end else begin
            bus.rsp_valid <= v1;
            if (v1) begin
                bus.rsp_id   <= id1;
                bus.rsp_sum  <= add_sum;
                bus.rsp_cout <= add_cout;
            end
        end
    end

    assign bus.busy = v1 | bus.rsp_valid;
endmodule

// File: tb/tb_cla512_rr_arbiter.sv
// Scoreboard bench for cla512_rr_arbiter: model grant order and wide sums, compare each response pulse.
module tb_cla512_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 512;
    localparam int IW   = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW:0]   res;
    } exp_t;

    logic clk;
    logic rst_n;

    cla512_rr_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .ID_W(IW)) bus ();

    cla512_rr_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mptr    = NREQ - 1;
    bit   exp_v1  = 1'b0;
    bit   exp_v2  = 1'b0;
    int   last_grant = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    // Called just after a falling edge with inputs already set; returns just after the next falling edge.
    task automatic cycle();
        int            w;
        int            idx;
        logic [NREQ-1:0] eg;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        exp_t          e;
        #1;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (w < 0 && bus.req_valid[idx]) w = idx;
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("grant", {{(DW+1-NREQ){1'b0}}, bus.req_ready}, {{(DW+1-NREQ){1'b0}}, eg});
        if (w >= 0) begin
            a = bus.req_a[w*DW +: DW];
            b = bus.req_b[w*DW +: DW];
        end else begin
            a = '0;
            b = '0;
        end
        @(posedge clk);
        exp_v2 = exp_v1;
        exp_v1 = (w >= 0);
        last_grant = w;
        if (w >= 0) begin
            e.id  = IW'(w);
            e.res = {1'b0, a} + {1'b0, b};
            sbq.push_back(e);
            mptr = w;
        end
        #1;
        chk("rsp_valid", (DW+1)'(bus.rsp_valid), (DW+1)'(exp_v2));
        chk("busy", (DW+1)'(bus.busy), (DW+1)'(exp_v1 | exp_v2));
        if (bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", (DW+1)'(bus.rsp_id), '1);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", (DW+1)'(bus.rsp_id), (DW+1)'(e.id));
                chk("rsp_result", {bus.rsp_cout, bus.rsp_sum}, e.res);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req_valid = '0;
        repeat (3) cycle();
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] half;
        ones = '1;
        half = '0;
        half[DW-1] = 1'b1;

        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        #2 rst_n = 1'b0;
        #1 bus.req_valid = 4'hF;
        #1;
        chk("reset_ready", (DW+1)'(bus.req_ready), '0);
        chk("reset_rsp_valid", (DW+1)'(bus.rsp_valid), '0);
        chk("reset_busy", (DW+1)'(bus.busy), '0);
        chk("reset_rsp_sum", {bus.rsp_cout, bus.rsp_sum}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation: all four valid, requester 0 first after reset.
        for (int i = 0; i < NREQ; i++) set_req(i, DW'(i), DW'(100));
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rot_grant", (DW+1)'(last_grant), (DW+1)'(k % 4));
        end
        drain();

        // Single requester 2: 5 + 7.
        set_req(2, DW'(5), DW'(7));
        bus.req_valid = 4'b0100;
        #1;
        chk("single_ready", (DW+1)'(bus.req_ready), (DW+1)'(4'b0100));
        cycle();
        bus.req_valid = '0;
        cycle();
        chk("single_valid", (DW+1)'(bus.rsp_valid), (DW+1)'(1));
        chk("single_id", (DW+1)'(bus.rsp_id), (DW+1)'(2));
        chk("single_sum", {bus.rsp_cout, bus.rsp_sum}, (DW+1)'(12));
        drain();

        // Full-width wrap and top-bit carry.
        set_req(1, ones, DW'(1));
        bus.req_valid = 4'b0010;
        cycle();
        set_req(1, half, half);
        cycle();
        chk("wrap_ones", {bus.rsp_cout, bus.rsp_sum}, {1'b1, {DW{1'b0}}});
        bus.req_valid = '0;
        cycle();
        chk("wrap_half", {bus.rsp_cout, bus.rsp_sum}, {1'b1, {DW{1'b0}}});
        drain();

        // Fairness after idle.
        for (int i = 0; i < NREQ; i++) set_req(i, DW'(1000 + i), DW'(i * 3));
        bus.req_valid = 4'b1000;
        cycle();
        chk("fair_first", (DW+1)'(last_grant), (DW+1)'(3));
        bus.req_valid = '0;
        repeat (3) cycle();
        bus.req_valid = 4'b1001;
        cycle();
        chk("fair_zero", (DW+1)'(last_grant), (DW+1)'(0));
        bus.req_valid = 4'b1000;
        cycle();
        chk("fair_three", (DW+1)'(last_grant), (DW+1)'(3));
        drain();

        // Withdrawal: with ptr=0, requester 1 drops before the edge.
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = 4'b0110;
        #1;
        chk("wd_pre_ready", (DW+1)'(bus.req_ready), (DW+1)'(4'b0010));
        bus.req_valid = 4'b0100;
        cycle();
        chk("wd_grant", (DW+1)'(last_grant), (DW+1)'(2));
        bus.req_valid = 4'b0110;
        cycle();
        chk("wd_ptr", (DW+1)'(last_grant), (DW+1)'(1));
        drain();

        // Reset with two operations in flight.
        bus.req_valid = 4'b0011;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", (DW+1)'(bus.rsp_valid), '0);
        chk("rst_busy", (DW+1)'(bus.busy), '0);
        chk("rst_ready", (DW+1)'(bus.req_ready), '0);
        sbq.delete();
        exp_v1 = 1'b0;
        exp_v2 = 1'b0;
        mptr = NREQ - 1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'b1010;
        cycle();
        chk("rst_next_grant", (DW+1)'(last_grant), (DW+1)'(1));
        drain();

        chk("sb_empty", (DW+1)'(sbq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
